// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master side drives req/done; the slave (arbiter) side drives gnt, gnt_valid and timeout.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a registered one-hot grant and an optional hold timeout.
// Latency: 1 cycle from req in IDLE to gnt. Backpressure: the owner holds gnt until done, req drop or timeout.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state_q, state_n;
  logic [7:0]       gnt_q, gnt_n;
  logic [2:0]       ptr_q, ptr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             tout_q, tout_n;

  logic             found;
  logic [2:0]       sel;
  logic             owner_req;
  logic             hold_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      tout_q  <= tout_n;
    end
  end

  // Search order starts at ptr and wraps modulo 8.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < 8; k++) begin
      if (!found && bus.req[ptr_q + 3'(k)]) begin
        found = 1'b1;
        sel   = ptr_q + 3'(k);
      end
    end
  end

  assign owner_req = |(bus.req & gnt_q);
  assign hold_exp  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    tout_n  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          gnt_n   = 8'b1 << sel;
          ptr_n   = sel + 3'd1;
          cnt_n   = CNT_W'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        // Every release passes through IDLE, which enforces the one-cycle gap.
        if (bus.done || !owner_req || hold_exp) begin
          gnt_n   = '0;
          state_n = IDLE;
          tout_n  = hold_exp && !bus.done && owner_req;
        end else if (cnt_q != '1) begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = tout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed-vector bench for rr_arbiter_8 with MAX_HOLD=4.
module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_arbiter_8_if bus();

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #3;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%h vld=%b tout=%b, want 00/0/0", bus.gnt, bus.gnt_valid, bus.timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.done = (c == 2);
      tick();
      checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req cyc%0d: gnt=%h vld=%b tout=%b, want 00/0/0", c, bus.gnt, bus.gnt_valid, bus.timeout);
      end
    end
    bus.done = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [7:0] exp [4];
    exp[0] = 8'h04; exp[1] = 8'h10; exp[2] = 8'h80; exp[3] = 8'h04;
    do_reset();
    bus.req = 8'b1001_0100;
    for (int g = 0; g < 4; g++) begin
      tick();
      checks++;
      if (bus.gnt !== exp[g] || bus.gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%h vld=%b, want %h/1", g, bus.gnt, bus.gnt_valid, exp[g]);
      end
      tick();
      checks++;
      if (bus.gnt !== exp[g]) begin
        errors++;
        $display("FAIL rr_hold%0d: gnt=%h, want %h", g, bus.gnt, exp[g]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: gnt=%h vld=%b tout=%b, want 00/0/0", g, bus.gnt, bus.gnt_valid, bus.timeout);
      end
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_wraparound;
    do_reset();
    bus.req = 8'h10;
    tick();
    checks++;
    if (bus.gnt !== 8'h10) begin
      errors++;
      $display("FAIL wrap_setup: gnt=%h, want 10", bus.gnt);
    end
    bus.req = 8'b0000_0011;
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release: gnt=%h tout=%b, want 00/0", bus.gnt, bus.timeout);
    end
    tick();
    checks++;
    if (bus.gnt !== 8'h01) begin
      errors++;
      $display("FAIL wrap_grant: gnt=%h, want 01", bus.gnt);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 8'h02) begin
      errors++;
      $display("FAIL wrap_next: gnt=%h, want 02", bus.gnt);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    bus.req = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.gnt !== 8'h08 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL tout_hold cyc%0d: gnt=%h tout=%b, want 08/0", c, bus.gnt, bus.timeout);
      end
    end
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1) begin
      errors++;
      $display("FAIL tout_release: gnt=%h vld=%b tout=%b, want 00/0/1", bus.gnt, bus.gnt_valid, bus.timeout);
    end
    tick();
    checks++;
    if (bus.gnt !== 8'h08 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL tout_regrant: gnt=%h tout=%b, want 08/0", bus.gnt, bus.timeout);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_owner_drop;
    do_reset();
    bus.req = 8'h20;
    tick();
    checks++;
    if (bus.gnt !== 8'h20) begin
      errors++;
      $display("FAIL drop_setup: gnt=%h, want 20", bus.gnt);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: gnt=%h tout=%b, want 00/0", bus.gnt, bus.timeout);
    end
    bus.req = 8'h20;
    repeat (4) tick();
    checks++;
    if (bus.gnt !== 8'h20) begin
      errors++;
      $display("FAIL done_tout_setup: gnt=%h, want 20", bus.gnt);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL done_tout_release: gnt=%h tout=%b, want 00/0", bus.gnt, bus.timeout);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.req = 8'h40;
    tick();
    checks++;
    if (bus.gnt !== 8'h40) begin
      errors++;
      $display("FAIL arst_setup: gnt=%h, want 40", bus.gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL arst_async: gnt=%h vld=%b tout=%b, want 00/0/0", bus.gnt, bus.gnt_valid, bus.timeout);
    end
    bus.req = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL arst_first: gnt=%h vld=%b tout=%b, want 01/1/0", bus.gnt, bus.gnt_valid, bus.timeout);
    end
    bus.req = 8'h00;
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_round_robin();
    test_wraparound();
    test_timeout();
    test_owner_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter that produces a registered one-hot grant vector.
- Sits directly upstream of the 8-to-3 one-hot encoder: gnt[7:0] drives the encoder input, and gnt_valid qualifies the encoder output.
- gnt is guaranteed to be exactly one-hot or all-zero, so the encoder never sees a multi-hot input.
- Grants are held until the owner releases them or a hold-timeout expires.

Parameters:
- MAX_HOLD, 16: maximum number of consecutive cycles one grant may be held before a forced release. 0 disables the timeout. Legal range 0..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  the current owner releases the grant; sampled only in GRANT.
- gnt  output  8  registered one-hot grant, or 8'h00 when idle.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - gnt=8'h00, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0, hold counter=0, state=IDLE.
- State machine, two states:
  - IDLE: no grant outstanding.
  - GRANT: one requester owns the resource.
- IDLE:
  - If req==0: stay in IDLE; outputs unchanged (zero).
  - Otherwise select i = the first set bit of req, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (wrap modulo 8).
  - On the next edge: gnt=1<<i, gnt_valid=1, ptr=(i+1) mod 8, counter=1, state=GRANT.
  - Latency from a req edge seen in IDLE to gnt asserted: 1 cycle.
- GRANT, with owner bit o:
  - Release condition: done=1, OR req[o]=0, OR (MAX_HOLD!=0 AND counter==MAX_HOLD).
  - On release: next edge gnt=0, gnt_valid=0, state=IDLE.
  - If the release is caused only by the timeout (done=0 and req[o]=1), timeout=1 for that one cycle. Otherwise timeout stays 0.
  - No release: gnt holds and the counter increments, saturating at 2**CNT_W-1.
- Mandatory gap: at least one IDLE cycle (gnt=0) between any two grants, including a re-grant to the same requester. No back-to-back handoff in the same edge.
- ptr advances only when a grant is issued, never on release. Fairness: a continuously asserted requester waits at most 7 other grants.
- Changes on other req bits while in GRANT are ignored until the next IDLE cycle.
- done asserted in IDLE is ignored.
- Simultaneous events:
  - done and the timeout condition in the same cycle: this is a normal release, timeout=0.
  - done together with new requests: release first; arbitration happens in the following IDLE cycle using the updated ptr.
- Reset mid-grant: gnt drops to 0 immediately (asynchronously), ptr returns to 0, and no timeout pulse is produced.
- Invariants:
  - gnt is never multi-hot.
  - gnt_valid == |gnt at all times.
  - timeout is never high for two consecutive cycles.

Test Plan:
1. Reset then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0, timeout=0 throughout.
2. From reset, req=8'b1001_0100 held, with done pulsed 2 cycles after each grant -> grants in order 8'h04, 8'h10, 8'h80, 8'h04, each separated by one gnt=0 cycle.
3. ptr=5 (after granting bit 4) and req=8'b0000_0011 -> next grant 8'h01 (wrap-around), then ptr=1; with 8'h01 released, the following grant is 8'h02.
4. MAX_HOLD=4, req[3] held, done=0 -> gnt=8'h08 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle; the next cycle re-grants 8'h08 if it is the only requester.
5. Owner drops req mid-grant: gnt=8'h20 and req[5] deasserted -> gnt=0 on the next edge, timeout=0. Also, done and counter==MAX_HOLD in the same cycle -> release with timeout=0.
6. Assert rst_n=0 asynchronously mid-grant while gnt=8'h40 -> gnt=0 and gnt_valid=0 without waiting for a clock edge; after release, req=8'hFF -> first grant 8'h01.
